// File: rtl/morphology_pkg.sv
// Shared types for the morphology filter: kernel identifiers and the kernel-LUT loader states.
package morphology_pkg;

    localparam int NUM_KERNELS = 8;
    localparam int KID_W       = $clog2(NUM_KERNELS);

    // Order also defines the position of each kernel within a config set.
    typedef enum logic [KID_W-1:0] {
        UP_OP_ERO,
        UP_OP_DILA,
        UP_CL_ERO,
        UP_CL_DILA,
        LO_OP_ERO,
        LO_OP_DILA,
        LO_CL_ERO,
        LO_CL_DILA
    } kernel_id_e;

    typedef enum logic [1:0] {
        LOAD,
        PEND,
        DRAIN
    } lut_fsm_e;

endpackage

// File: rtl/kernel_lut_ram.sv
// One kernel's double-buffered coefficient store: one write port into the shadow bank,
// one registered read port from the active bank.
module kernel_lut_ram #(
    parameter int KERNEL_WIDTH      = 71,
    parameter int KERNEL_DATA_WIDTH = 8,
    parameter int ADDR_WIDTH        = $clog2(KERNEL_WIDTH)
) (
    input  logic                         clk,
    input  logic                         areset,
    input  logic                         we,
    input  logic                         wbank,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [KERNEL_DATA_WIDTH-1:0] wdata,
    input  logic                         ren,
    input  logic                         rbank,
    input  logic [ADDR_WIDTH-1:0]        raddr,
    output logic [KERNEL_DATA_WIDTH-1:0] rdata
);

    logic [KERNEL_DATA_WIDTH-1:0] mem [2][KERNEL_WIDTH];

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) mem[wbank][waddr] <= wdata;
    end

    // ren already folds in address range and set validity, so a dropped read returns zero.
    always_ff @(posedge clk or posedge areset) begin
        if (areset)   rdata <= '0;
        else if (ren) rdata <= mem[rbank][raddr];
        else          rdata <= '0;
    end

endmodule

// File: rtl/morphology_kernel_lut_bank.sv
// Kernel-LUT responder: loads full kernel sets from a config stream into a shadow bank
// and swaps banks atomically at swap_en, serving all kernels to the filter every cycle.
module morphology_kernel_lut_bank
    import morphology_pkg::*;
#(
    parameter  int KERNEL_WIDTH      = 71,
    parameter  int KERNEL_DATA_WIDTH = 8,
    localparam int ADDR_WIDTH        = $clog2(KERNEL_WIDTH)
) (
    input  logic                                          clk,
    input  logic                                          areset,
    input  logic [KERNEL_DATA_WIDTH-1:0]                  axis_cfg_tdata,
    input  logic                                          axis_cfg_tvalid,
    output logic                                          axis_cfg_tready,
    input  logic                                          axis_cfg_tlast,
    input  logic                                          swap_en,
    input  logic [NUM_KERNELS-1:0][ADDR_WIDTH-1:0]        lut_address,
    output logic [NUM_KERNELS-1:0][KERNEL_DATA_WIDTH-1:0] lut_data,
    output logic                                          kernel_valid,
    output logic                                          active_bank,
    output logic                                          load_error
);

    lut_fsm_e                state, state_nxt;
    logic [KID_W-1:0]        kernel_cnt;
    logic [ADDR_WIDTH-1:0]   tap_cnt;
    logic                    beat, last_beat;
    logic                    wr_en, cnt_clr, cnt_inc, swap_fire, err_fire;

    assign beat      = axis_cfg_tvalid && axis_cfg_tready;
    assign last_beat = (kernel_cnt == KID_W'(NUM_KERNELS - 1)) &&
                       (tap_cnt == ADDR_WIDTH'(KERNEL_WIDTH - 1));

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (beat && last_beat) state_nxt = axis_cfg_tlast ? PEND : DRAIN;
            end
            DRAIN: begin
                if (beat && axis_cfg_tlast) state_nxt = LOAD;
            end
            PEND: begin
                if (swap_en) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // A tlast before the final beat, or a final beat missing tlast, both mark the set malformed.
    always_comb begin
        axis_cfg_tready = (state != PEND);
        wr_en           = (state == LOAD) && beat;
        swap_fire       = (state == PEND) && swap_en;
        err_fire        = wr_en && (axis_cfg_tlast != last_beat);
        cnt_inc         = wr_en;
        cnt_clr         = (wr_en && axis_cfg_tlast && !last_beat) ||
                          ((state == DRAIN) && beat && axis_cfg_tlast) ||
                          swap_fire;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            kernel_cnt <= '0;
            tap_cnt    <= '0;
        end else if (cnt_clr) begin
            kernel_cnt <= '0;
            tap_cnt    <= '0;
        end else if (cnt_inc) begin
            if (tap_cnt == ADDR_WIDTH'(KERNEL_WIDTH - 1)) begin
                tap_cnt    <= '0;
                kernel_cnt <= kernel_cnt + 1'b1;
            end else begin
                tap_cnt <= tap_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            active_bank  <= 1'b0;
            kernel_valid <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            load_error <= err_fire;
            if (swap_fire) begin
                active_bank  <= ~active_bank;
                kernel_valid <= 1'b1;
            end
        end
    end

    // Reads sample active_bank before the swap edge, so a swap-cycle read still sees the old set.
    for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_kernel
        logic in_range;
        assign in_range = {1'b0, lut_address[k]} < (ADDR_WIDTH + 1)'(KERNEL_WIDTH);

        kernel_lut_ram #(
            .KERNEL_WIDTH      (KERNEL_WIDTH),
            .KERNEL_DATA_WIDTH (KERNEL_DATA_WIDTH),
            .ADDR_WIDTH        (ADDR_WIDTH)
        ) u_ram (
            .clk   (clk),
            .areset(areset),
            .we    (wr_en && (kernel_cnt == KID_W'(k))),
            .wbank (~active_bank),
            .waddr (tap_cnt),
            .wdata (axis_cfg_tdata),
            .ren   (kernel_valid && in_range),
            .rbank (active_bank),
            .raddr (lut_address[k]),
            .rdata (lut_data[k])
        );
    end

endmodule

// File: tb/tb_morphology_kernel_lut_bank.sv
// Directed bench for the kernel-LUT bank: table-driven reads plus load/swap/error sequences.
module tb_morphology_kernel_lut_bank;

    localparam int KW = 71;
    localparam int NK = 8;
    localparam int SET_BEATS = NK * KW;

    logic             clk = 1'b0;
    logic             areset;
    logic [7:0]       axis_cfg_tdata;
    logic             axis_cfg_tvalid;
    logic             axis_cfg_tready;
    logic             axis_cfg_tlast;
    logic             swap_en;
    logic [NK-1:0][6:0] lut_address;
    logic [NK-1:0][7:0] lut_data;
    logic             kernel_valid;
    logic             active_bank;
    logic             load_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    morphology_kernel_lut_bank dut (
        .clk            (clk),
        .areset         (areset),
        .axis_cfg_tdata (axis_cfg_tdata),
        .axis_cfg_tvalid(axis_cfg_tvalid),
        .axis_cfg_tready(axis_cfg_tready),
        .axis_cfg_tlast (axis_cfg_tlast),
        .swap_en        (swap_en),
        .lut_address    (lut_address),
        .lut_data       (lut_data),
        .kernel_valid   (kernel_valid),
        .active_bank    (active_bank),
        .load_error     (load_error)
    );

    typedef struct {
        int         phase;
        int         k;
        logic [6:0] addr;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // mode 0: (k*16+tap) mod 128, mode 1: all -1, mode 2: mode 0 with bit 7 flipped
    function automatic logic [7:0] coef(input int mode, input int k, input int tap);
        logic [7:0] base;
        base = 8'((k * 16 + tap) % 128);
        case (mode)
            0:       return base;
            1:       return 8'hFF;
            default: return base ^ 8'h80;
        endcase
    endfunction

    task automatic send(input int n, input int tlast_at, input int mode,
                        input int chk_k, input logic [7:0] chk_exp);
        for (int i = 0; i < n; i++) begin
            axis_cfg_tdata  = coef(mode, (i / KW) % NK, i % KW);
            axis_cfg_tvalid = 1'b1;
            axis_cfg_tlast  = (i == tlast_at);
            @(posedge clk); #1;
            if (chk_k >= 0) check("cont_read", 64'(lut_data[chk_k]), 64'(chk_exp));
        end
        axis_cfg_tvalid = 1'b0;
        axis_cfg_tlast  = 1'b0;
    endtask

    task automatic do_swap();
        swap_en = 1'b1;
        @(posedge clk); #1;
        swap_en = 1'b0;
    endtask

    task automatic apply_phase(input int p);
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].phase == p) begin
                lut_address = '0;
                lut_address[tbl[i].k] = tbl[i].addr;
                @(posedge clk); #1;
                check($sformatf("tbl%0d_k%0d_a%0d", i, tbl[i].k, tbl[i].addr),
                      64'(lut_data[tbl[i].k]), 64'(tbl[i].exp));
            end
        end
    endtask

    initial begin
        tbl[0]  = '{1, 2, 7'd5,   8'd37};
        tbl[1]  = '{1, 0, 7'd1,   8'd1};
        tbl[2]  = '{1, 7, 7'd70,  8'd54};
        tbl[3]  = '{1, 5, 7'd10,  8'd90};
        tbl[4]  = '{1, 6, 7'd69,  8'd37};
        tbl[5]  = '{1, 3, 7'd71,  8'd0};
        tbl[6]  = '{1, 4, 7'd127, 8'd0};
        tbl[7]  = '{3, 0, 7'd0,   8'hFF};
        tbl[8]  = '{3, 7, 7'd70,  8'hFF};
        tbl[9]  = '{3, 4, 7'd35,  8'hFF};
        tbl[10] = '{4, 0, 7'd0,   8'h80};
        tbl[11] = '{4, 2, 7'd5,   8'hA5};
        tbl[12] = '{4, 7, 7'd70,  8'hB6};
        tbl[13] = '{4, 1, 7'd70,  8'hD6};
        tbl[14] = '{5, 1, 7'd0,   8'd16};
        tbl[15] = '{5, 0, 7'd1,   8'd1};
        tbl[16] = '{5, 3, 7'd71,  8'd0};
        tbl[17] = '{5, 2, 7'd5,   8'd37};
        tbl[18] = '{5, 6, 7'd0,   8'd96};
        tbl[19] = '{5, 7, 7'd71,  8'd0};

        areset          = 1'b1;
        axis_cfg_tdata  = '0;
        axis_cfg_tvalid = 1'b0;
        axis_cfg_tlast  = 1'b0;
        swap_en         = 1'b0;
        lut_address     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 64'(axis_cfg_tready), 64'd1);
        check("rst_kvalid", 64'(kernel_valid), 64'd0);
        check("rst_bank",   64'(active_bank), 64'd0);
        check("rst_err",    64'(load_error), 64'd0);
        check("rst_data",   64'(lut_data), 64'd0);
        areset = 1'b0;
        @(posedge clk); #1;

        // 1: first set, swap, table reads
        send(SET_BEATS, SET_BEATS - 1, 0, -1, 8'd0);
        check("t1_err",    64'(load_error), 64'd0);
        check("t1_pend_tready", 64'(axis_cfg_tready), 64'd0);
        check("t1_pend_kvalid", 64'(kernel_valid), 64'd0);
        do_swap();
        check("t1_kvalid", 64'(kernel_valid), 64'd1);
        check("t1_bank",   64'(active_bank), 64'd1);
        check("t1_tready", 64'(axis_cfg_tready), 64'd1);
        apply_phase(1);

        // 2/3: -1 set loaded under continuous reads, swap held off, then swap-cycle boundary
        lut_address    = '0;
        lut_address[2] = 7'd5;
        lut_address[7] = 7'd70;
        send(SET_BEATS, SET_BEATS - 1, 1, 2, 8'd37);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t2_hold_tready", 64'(axis_cfg_tready), 64'd0);
            check("t2_hold_data",   64'(lut_data[2]), 64'd37);
            check("t2_hold_bank",   64'(active_bank), 64'd1);
        end
        do_swap();
        check("t3_swap_old", 64'(lut_data[2]), 64'd37);
        check("t3_swap_old7", 64'(lut_data[7]), 64'd54);
        check("t3_bank", 64'(active_bank), 64'd0);
        @(posedge clk); #1;
        check("t3_new",  64'(lut_data[2]), 64'hFF);
        check("t3_new7", 64'(lut_data[7]), 64'hFF);
        apply_phase(3);

        // 4: early tlast on beat 100, then a clean set
        lut_address    = '0;
        lut_address[2] = 7'd5;
        send(101, 100, 2, 2, 8'hFF);
        check("t4_err_pulse", 64'(load_error), 64'd1);
        check("t4_tready", 64'(axis_cfg_tready), 64'd1);
        @(posedge clk); #1;
        check("t4_err_clear", 64'(load_error), 64'd0);
        check("t4_bank_kept", 64'(active_bank), 64'd0);
        send(SET_BEATS, SET_BEATS - 1, 2, 2, 8'hFF);
        check("t4_set_err", 64'(load_error), 64'd0);
        do_swap();
        check("t4_bank", 64'(active_bank), 64'd1);
        apply_phase(4);

        // 5: full set without tlast, drain three beats, no swap possible
        lut_address    = '0;
        lut_address[2] = 7'd5;
        send(SET_BEATS, -1, 0, 2, 8'hA5);
        check("t5_err_pulse", 64'(load_error), 64'd1);
        check("t5_drain_tready", 64'(axis_cfg_tready), 64'd1);
        send(3, 2, 1, 2, 8'hA5);
        check("t5_drain_err", 64'(load_error), 64'd0);
        do_swap();
        check("t5_no_swap_bank", 64'(active_bank), 64'd1);
        check("t5_no_swap_data", 64'(lut_data[2]), 64'hA5);
        send(SET_BEATS, SET_BEATS - 1, 0, 2, 8'hA5);
        check("t5_reload_tready", 64'(axis_cfg_tready), 64'd0);
        do_swap();
        check("t5_bank", 64'(active_bank), 64'd0);
        apply_phase(5);

        // 6: reset in the middle of a load
        lut_address    = '0;
        lut_address[2] = 7'd5;
        send(300, -1, 2, 2, 8'd37);
        #2;
        areset = 1'b1;
        #1;
        check("t6_tready", 64'(axis_cfg_tready), 64'd1);
        check("t6_kvalid", 64'(kernel_valid), 64'd0);
        check("t6_bank",   64'(active_bank), 64'd0);
        check("t6_err",    64'(load_error), 64'd0);
        check("t6_data",   64'(lut_data), 64'd0);
        @(posedge clk); #1;
        areset = 1'b0;
        @(posedge clk); #1;
        check("t6_post_data", 64'(lut_data), 64'd0);
        check("t6_post_kvalid", 64'(kernel_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
